// File: rtl/drink_pkg.sv
// Shared constants and dispenser state encoding for the two-slot drink scheduler.
package drink_pkg;

  localparam int unsigned PRICE       = 4;
  localparam int unsigned DISP_CYCLES = 3;
  localparam int unsigned CNT_W       = $clog2(DISP_CYCLES);

  localparam logic [1:0] COIN_NONE   = 2'd0;
  localparam logic [1:0] COIN_HALF   = 2'd1;
  localparam logic [1:0] COIN_ONE    = 2'd2;
  localparam logic [1:0] COIN_CANCEL = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/drink_slot.sv
// One coin slot: credit accumulation, dispense/refund pending flags and ready handshake.
module drink_slot
  import drink_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_vld,
  input  logic [1:0] coin,
  input  logic       grant,
  output logic [2:0] credit,
  output logic       pend_disp,
  output logic       pend_ref,
  output logic       coin_rdy
);

  logic [2:0] credit_q, credit_d;
  logic       pend_disp_q, pend_disp_d;
  logic       pend_ref_q, pend_ref_d;
  logic       accept;

  assign coin_rdy  = !(pend_disp_q | pend_ref_q);
  assign accept    = coin_vld & coin_rdy;
  assign credit    = credit_q;
  assign pend_disp = pend_disp_q;
  assign pend_ref  = pend_ref_q;

  // A grant only arrives while a flag is set, so it never coincides with an accepted coin.
  always_comb begin
    credit_d    = credit_q;
    pend_disp_d = pend_disp_q;
    pend_ref_d  = pend_ref_q;
    if (grant) begin
      credit_d    = '0;
      pend_disp_d = 1'b0;
      pend_ref_d  = 1'b0;
    end else if (accept) begin
      case (coin)
        COIN_HALF, COIN_ONE: begin
          credit_d = credit_q + {1'b0, coin};
          if (credit_d >= 3'(PRICE)) pend_disp_d = 1'b1;
        end
        COIN_CANCEL: begin
          if (credit_q != '0) pend_ref_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q    <= '0;
      pend_disp_q <= 1'b0;
      pend_ref_q  <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      pend_disp_q <= pend_disp_d;
      pend_ref_q  <= pend_ref_d;
    end
  end

endmodule

// File: rtl/drink_sched.sv
// Two-slot drink machine: round-robin arbiter between slots and dispenser IDLE/BUSY FSM.
module drink_sched
  import drink_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_vld0,
  input  logic       coin_vld1,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  output logic       coin_rdy0,
  output logic       coin_rdy1,
  output logic       drink,
  output logic [1:0] back,
  output logic       ev_vld,
  output logic       ev_id,
  output logic       busy
);

  logic [2:0] credit0, credit1;
  logic       pend_disp0, pend_disp1, pend_ref0, pend_ref1;
  logic       grant0, grant1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             drink_q, drink_d;
  logic             ev_vld_q, ev_vld_d;
  logic             ev_id_q, ev_id_d;
  logic [1:0]       back_q, back_d;

  logic             pend0, pend1, win;
  logic [2:0]       win_credit;
  logic             win_disp;

  drink_slot u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .coin_vld  (coin_vld0),
    .coin      (coin0),
    .grant     (grant0),
    .credit    (credit0),
    .pend_disp (pend_disp0),
    .pend_ref  (pend_ref0),
    .coin_rdy  (coin_rdy0)
  );

  drink_slot u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .coin_vld  (coin_vld1),
    .coin      (coin1),
    .grant     (grant1),
    .credit    (credit1),
    .pend_disp (pend_disp1),
    .pend_ref  (pend_ref1),
    .coin_rdy  (coin_rdy1)
  );

  assign pend0      = pend_disp0 | pend_ref0;
  assign pend1      = pend_disp1 | pend_ref1;
  // On contention the slot that did not win last time goes first.
  assign win        = (pend0 & pend1) ? ~last_grant_q : pend1;
  assign win_credit = win ? credit1 : credit0;
  assign win_disp   = win ? pend_disp1 : pend_disp0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    drink_d      = 1'b0;
    ev_vld_d     = 1'b0;
    back_d       = '0;
    ev_id_d      = ev_id_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend0 | pend1) begin
          grant0       = ~win;
          grant1       = win;
          last_grant_d = win;
          ev_vld_d     = 1'b1;
          ev_id_d      = win;
          if (win_disp) begin
            drink_d = 1'b1;
            back_d  = 2'(win_credit - 3'(PRICE));
            state_d = BUSY;
            cnt_d   = CNT_W'(DISP_CYCLES - 1);
          end else begin
            back_d  = win_credit[1:0];
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      drink_q      <= 1'b0;
      ev_vld_q     <= 1'b0;
      ev_id_q      <= 1'b0;
      back_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      drink_q      <= drink_d;
      ev_vld_q     <= ev_vld_d;
      ev_id_q      <= ev_id_d;
      back_q       <= back_d;
    end
  end

  assign drink  = drink_q;
  assign ev_vld = ev_vld_q;
  assign ev_id  = ev_id_q;
  assign back   = back_q;
  assign busy   = (state_q == BUSY);

endmodule

// File: doc/drink_sched.md
DRINK_SCHED -- requirements
Module: drink_sched

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: coin_vld0/coin_vld1  in  1  slot 0/1 coin strobe.
REQ-004 SHALL have ports: coin0/coin1  in  2  slot coin code: 0 none, 1 half-unit (+1 credit), 2 one-unit (+2 credit), 3 cancel.
REQ-005 SHALL have ports: coin_rdy0/coin_rdy1  out  1  slot can accept a coin this cycle.
REQ-006 SHALL have port: drink  out  1  one-cycle pulse, a drink is dispensed.
REQ-007 SHALL have port: back  out  2  change or refund in credit units, valid only while ev_vld=1.
REQ-008 SHALL have port: ev_vld  out  1  one-cycle pulse, output event (dispense or refund) present.
REQ-009 SHALL have port: ev_id  out  1  slot owning the current event.
REQ-010 SHALL have port: busy  out  1  dispenser in BUSY state.

Function
REQ-011 SHALL treat a coin as accepted at a rising edge when coin_vld=1 and coin_rdy=1; otherwise it is ignored and the credit is unchanged.
REQ-012 SHALL keep a 3-bit credit per slot; codes 1/2 add 1/2; code 0 leaves credit unchanged.
REQ-013 SHALL set slot pend_disp when the updated credit is >= PRICE (4); maximum reachable credit is 5.
REQ-014 SHALL, on accepted code 3 with credit > 0, set slot pend_ref; with credit 0, accept and discard it (no event).
REQ-015 SHALL drive coin_rdy = !(pend_disp | pend_ref) for each slot, combinationally from registers.
REQ-016 SHALL use two dispenser states: IDLE, BUSY.
REQ-017 SHALL arbitrate only in IDLE, among slots with a pending flag; a single pending slot wins.
REQ-018 SHALL resolve contention round-robin: the slot not equal to last_grant wins; last_grant updates on every grant.
REQ-019 SHALL, on a dispense grant, register at that edge: drink=1, ev_vld=1, ev_id=slot, back=credit-4 (0 or 1), credit=0, pend_disp=0, state=BUSY.
REQ-020 SHALL, on a refund grant, register: drink=0, ev_vld=1, ev_id=slot, back=credit (1..3), credit=0, pend_ref=0, state remains IDLE.
REQ-021 SHALL hold drink, ev_vld, back at 0 in every cycle without a grant (pulse width exactly one cycle).
REQ-022 SHALL remain in BUSY for DISP_CYCLES (3) cycles after the drink pulse, then return to IDLE; the next grant occurs at the earliest on the 4th edge after the dispense-grant edge.
REQ-023 SHALL permit coin acceptance on the non-granted slot during BUSY; pending flags persist until granted.
REQ-024 SHALL take minimum latency of one edge from accepting the completing coin to the event edge (accept at edge k, event registered at edge k+1 when IDLE and won).
REQ-025 SHALL let a granted slot accept a new coin on the edge after its grant (coin_rdy rises after flag clears).

Reset
REQ-026 SHALL on reset asynchronously clear credits, pending flags, drink, back, ev_vld, ev_id, busy to 0, set state IDLE and last_grant=1 (slot 0 wins first contention).
REQ-027 SHALL discard any in-progress BUSY count and unpaid credit on reset mid-operation; no event is emitted for them.

Structure
REQ-028 SHALL place PRICE, DISP_CYCLES, coin code constants and the IDLE/BUSY state encoding in a shared package drink_pkg.
REQ-029 SHALL implement per-slot credit/pending logic as sub-module drink_slot, instantiated twice; arbiter and dispenser FSM reside in drink_sched.

Verification
REQ-030 SHALL cover: slot0 coins 2,2 on consecutive edges -> drink=1, back=0, ev_id=0 one edge later; busy high 3 cycles.
REQ-031 SHALL cover: slot1 coins 1,2,2 -> credit 5, drink=1, back=1, ev_id=1; coin_rdy1 low from pend set until grant.
REQ-032 SHALL cover: slot0 and slot1 both reach 4 on same edge after reset -> slot0 event first, slot1 drink exactly 4 edges later.
REQ-033 SHALL cover: slot0 coins 1,2 then 3 -> drink=0, ev_vld=1, back=3, ev_id=0; cancel at credit 0 -> no ev_vld.
REQ-034 SHALL cover: slot1 refund pending while slot0 dispensing (BUSY) -> refund emitted on first IDLE edge; slot0 coin_vld with rdy=0 ignored.
REQ-035 SHALL cover: reset asserted mid-BUSY with credit 3 on slot1 -> all outputs 0 immediately, no later event without new coins.
